// File: rtl/lbist_seq_ctrl.sv
// LBIST sequencer: walks N_SEEDS seeds, runs PATTERNS shift/capture patterns per seed and
// compares the MISR signature against golden values (once at the end or after every seed).
module lbist_seq_ctrl #(
  parameter int unsigned N_SEEDS    = 16,
  parameter int unsigned SEED_AW    = 4,
  parameter int unsigned PATTERNS   = 1024,
  parameter int unsigned SCAN_LEN   = 64,
  parameter int unsigned N_MISR     = 64,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned CMP_MODE   = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               test_i,
  input  logic [N_MISR-1:0]  misr_sig_i,
  input  logic [N_MISR-1:0]  golden_sig_i,
  output logic [SEED_AW-1:0] seed_addr_o,
  output logic               lfsr_ld_o,
  output logic               lfsr_en_o,
  output logic               misr_en_o,
  output logic               scan_en_o,
  output logic               dut_rst_no,
  output logic               tpg_rst_no,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic               fail_valid_o,
  output logic [SEED_AW-1:0] fail_seed_o
);

  localparam int unsigned PAT_W = $clog2(PATTERNS + 1);
  localparam int unsigned SHF_W = $clog2(SCAN_LEN + 1);
  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);

  localparam logic [PAT_W-1:0]   PAT_LAST  = PAT_W'(PATTERNS - 1);
  localparam logic [SHF_W-1:0]   SHF_LAST  = SHF_W'(SCAN_LEN - 1);
  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [SEED_AW-1:0] LAST_SEED = SEED_AW'(N_SEEDS - 1);
  localparam bit                 PER_SEED  = (CMP_MODE != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_COMPARE,
    S_CLR,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [SHF_W-1:0]     shf_cnt_q, shf_cnt_d;
  logic [PAT_W-1:0]     pat_cnt_q, pat_cnt_d;
  logic [SEED_AW-1:0]   seed_q, seed_d;
  logic                 fail_valid_q, fail_valid_d;
  logic [SEED_AW-1:0]   fail_seed_q, fail_seed_d;

  logic lfsr_ld_q, lfsr_ld_d;
  logic lfsr_en_q, lfsr_en_d;
  logic misr_en_q, misr_en_d;
  logic scan_en_q, scan_en_d;
  logic dut_rst_n_q, dut_rst_n_d;
  logic tpg_rst_n_q, tpg_rst_n_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pass_q, pass_d;

  logic seeds_left;
  logic sig_match;
  logic abort;

  assign seeds_left = (seed_q < LAST_SEED);
  assign sig_match  = (misr_sig_i == golden_sig_i);
  assign abort      = !test_i && (state_q != S_IDLE) && (state_q != S_DONE);

  // Next-state, counters and result tracking
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    shf_cnt_d    = shf_cnt_q;
    pat_cnt_d    = pat_cnt_q;
    seed_d       = seed_q;
    fail_valid_d = fail_valid_q;
    fail_seed_d  = fail_seed_q;

    unique case (state_q)
      S_IDLE: begin
        if (test_i) begin
          state_d      = S_RST;
          rst_cnt_d    = '0;
          seed_d       = '0;
          fail_valid_d = 1'b0;
          fail_seed_d  = '0;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_LOAD;
          seed_d  = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_LOAD: begin
        state_d   = S_SHIFT;
        pat_cnt_d = '0;
        shf_cnt_d = '0;
      end
      S_SHIFT: begin
        if (shf_cnt_q == SHF_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          shf_cnt_d = shf_cnt_q + SHF_W'(1);
        end
      end
      S_CAPTURE: begin
        if (pat_cnt_q < PAT_LAST) begin
          state_d   = S_SHIFT;
          pat_cnt_d = pat_cnt_q + PAT_W'(1);
          shf_cnt_d = '0;
        end else if (PER_SEED || !seeds_left) begin
          state_d = S_COMPARE;
        end else begin
          state_d = S_LOAD;
          seed_d  = seed_q + SEED_AW'(1);
        end
      end
      S_COMPARE: begin
        // Only the first mismatching seed is recorded
        if (!sig_match && !fail_valid_q) begin
          fail_valid_d = 1'b1;
          fail_seed_d  = seed_q;
        end
        if (PER_SEED && seeds_left) begin
          state_d = S_CLR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_CLR: begin
        state_d = S_LOAD;
        seed_d  = seed_q + SEED_AW'(1);
      end
      S_DONE: begin
        if (!test_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      rst_cnt_d    = '0;
      shf_cnt_d    = '0;
      pat_cnt_d    = '0;
      seed_d       = '0;
      fail_valid_d = 1'b0;
      fail_seed_d  = '0;
    end
  end

  // Output decode from the upcoming state so every output comes straight from a flop
  always_comb begin
    lfsr_ld_d   = 1'b0;
    lfsr_en_d   = 1'b0;
    misr_en_d   = 1'b0;
    scan_en_d   = 1'b0;
    dut_rst_n_d = 1'b1;
    tpg_rst_n_d = 1'b1;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    pass_d      = 1'b0;

    unique case (state_d)
      S_RST: begin
        dut_rst_n_d = 1'b0;
        tpg_rst_n_d = 1'b0;
        busy_d      = 1'b1;
      end
      S_LOAD: begin
        lfsr_ld_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_SHIFT: begin
        scan_en_d = 1'b1;
        lfsr_en_d = 1'b1;
        misr_en_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_CAPTURE: begin
        lfsr_en_d = 1'b1;
        misr_en_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_COMPARE: begin
        busy_d = 1'b1;
      end
      S_CLR: begin
        tpg_rst_n_d = 1'b0;
        busy_d      = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        pass_d = !fail_valid_d;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      shf_cnt_q    <= '0;
      pat_cnt_q    <= '0;
      seed_q       <= '0;
      fail_valid_q <= 1'b0;
      fail_seed_q  <= '0;
      lfsr_ld_q    <= 1'b0;
      lfsr_en_q    <= 1'b0;
      misr_en_q    <= 1'b0;
      scan_en_q    <= 1'b0;
      dut_rst_n_q  <= 1'b1;
      tpg_rst_n_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      shf_cnt_q    <= shf_cnt_d;
      pat_cnt_q    <= pat_cnt_d;
      seed_q       <= seed_d;
      fail_valid_q <= fail_valid_d;
      fail_seed_q  <= fail_seed_d;
      lfsr_ld_q    <= lfsr_ld_d;
      lfsr_en_q    <= lfsr_en_d;
      misr_en_q    <= misr_en_d;
      scan_en_q    <= scan_en_d;
      dut_rst_n_q  <= dut_rst_n_d;
      tpg_rst_n_q  <= tpg_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign seed_addr_o  = seed_q;
  assign lfsr_ld_o    = lfsr_ld_q;
  assign lfsr_en_o    = lfsr_en_q;
  assign misr_en_o    = misr_en_q;
  assign scan_en_o    = scan_en_q;
  assign dut_rst_no   = dut_rst_n_q;
  assign tpg_rst_no   = tpg_rst_n_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign fail_valid_o = fail_valid_q;
  assign fail_seed_o  = fail_seed_q;

endmodule

// File: doc/lbist_seq_ctrl.md
Name: lbist_seq_ctrl

Overview:
Parametrised LBIST sequencer, the next generation of the single-seed BIST controller around the RI5CY core. It walks N_SEEDS seeds from the seed ROM and runs PATTERNS scan-shift/capture patterns per seed. It drives the LFSR/MISR/scan/DUT-reset controls and compares the MISR signature against golden values, either once at the end or per seed. It also reports pass/fail and the index of the first failing seed.

Parameters:
N_SEEDS, 16, number of seeds applied (>=1)
SEED_AW, 4, seed address width, >= clog2(N_SEEDS)
PATTERNS, 1024, patterns per seed (>=1)
SCAN_LEN, 64, shift cycles per pattern (>=1)
N_MISR, 64, signature width
RST_CYCLES, 4, DUT/LFSR/MISR reset duration in cycles (>=1)
CMP_MODE, 1, 0 = single compare after last seed; 1 = compare and clear MISR per seed

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
test_i  in  1  level request; high starts a run, low aborts or rearms
misr_sig_i  in  N_MISR  current MISR signature
golden_sig_i  in  N_MISR  golden signature for seed_addr_o (combinational ROM read)
seed_addr_o  out  SEED_AW  seed ROM address = current seed index
lfsr_ld_o  out  1  load seed into LFSR
lfsr_en_o  out  1  LFSR step enable / TPG mux select
misr_en_o  out  1  MISR compaction enable
scan_en_o  out  1  scan shift enable
dut_rst_no  out  1  DUT/RAM reset, active low
tpg_rst_no  out  1  LFSR/MISR reset, active low
busy_o  out  1  run in progress
done_o  out  1  run complete
pass_o  out  1  all compares matched (valid when done_o)
fail_valid_o  out  1  at least one mismatch
fail_seed_o  out  SEED_AW  index of first failing seed

Behaviour:
- Reset (async, rst_ni low): state IDLE; all outputs 0 except dut_rst_no=1 and tpg_rst_no=1; counters and results cleared.
- All outputs are registered or decoded from state/counters only. No combinational path from inputs to outputs.
- IDLE: test_i high at an edge moves to RST. Entering RST clears pass/fail state.
- RST: RST_CYCLES cycles with dut_rst_no=0, tpg_rst_no=0, scan_en_o=0. Then LOAD with seed=0.
- LOAD: 1 cycle; lfsr_ld_o=1; dut_rst_no stays 1 from here on. Next state is SHIFT with pattern counter=0.
- SHIFT: SCAN_LEN cycles; scan_en_o=1, lfsr_en_o=1, misr_en_o=1. Then CAPTURE.
- CAPTURE: 1 cycle; scan_en_o=0, lfsr_en_o=1, misr_en_o=1.
  - If the pattern counter is less than PATTERNS-1: increment it and go to SHIFT.
  - Otherwise, end of seed:
    - CMP_MODE=1: go to COMPARE.
    - CMP_MODE=0: go to LOAD with seed+1 if seeds remain, else COMPARE.
- COMPARE: 1 cycle; lfsr_en_o=0, misr_en_o=0. Evaluate misr_sig_i == golden_sig_i.
  - On mismatch with fail_valid_o=0: set fail_valid_o=1 and fail_seed_o=seed.
  - Later mismatches do not overwrite fail_seed_o.
  - Next: CLR if CMP_MODE=1 and seeds remain, else DONE.
- CLR (CMP_MODE=1 only): 1 cycle; tpg_rst_no=0; then LOAD with seed+1.
- DONE: done_o=1, pass_o=~fail_valid_o, busy_o=0; all enables 0. Hold until test_i low, then IDLE. Results stay visible until the next run starts.
- busy_o=1 in every state other than IDLE and DONE.
- lfsr_en_o doubles as the TPG mux select, so it must be 0 in IDLE, RST, LOAD, COMPARE, CLR and DONE.
- Abort: test_i low in any state other than IDLE or DONE returns to IDLE on the next edge.
  - On abort: done_o stays 0, results are cleared, and dut_rst_no/tpg_rst_no read 1.
- seed_addr_o is held at the current seed through LOAD..COMPARE so golden_sig_i is settled at compare time.
- Counters: the pattern counter is sized clog2(PATTERNS+1) and the shift counter clog2(SCAN_LEN+1). Neither wraps within a seed.
- N_SEEDS=1: no CLR, and no second LOAD.

Test Plan:
- N_SEEDS=2, PATTERNS=3, SCAN_LEN=4, RST_CYCLES=2, CMP_MODE=1, golden matches; test_i sampled at edge 0.
  - Required: dut_rst_no=0 after edges 0-1; lfsr_ld_o after edges 2 and 20; tpg_rst_no pulse after edge 19.
  - Required: done_o=1 and pass_o=1 after edge 37.
- Same setup with CMP_MODE=0.
  - Required: no CLR pulse, LOAD after edges 2 and 18, single COMPARE after edge 34, done_o after edge 35.
- CMP_MODE=1, golden mismatched on seed 0 and seed 1.
  - Required: fail_valid_o=1, fail_seed_o=0, pass_o=0 at done.
  - Then mismatch only on seed 1 → fail_seed_o=1.
- Drop test_i mid-SHIFT of seed 1.
  - Required: IDLE next cycle, all enables 0, done_o=0.
  - Re-raising test_i restarts from RST with seed 0.
- Assert rst_ni low during CAPTURE.
  - Required: outputs take reset values immediately (asynchronously); nothing resumes until test_i is sampled again.
- Check scan_en_o high-cycle count per pattern = SCAN_LEN and misr_en_o high-cycle count per seed = PATTERNS*(SCAN_LEN+1).
  - Required: 15 misr_en_o cycles per seed with the small parameters.
